fnd_scan_controller: RTL and testbench

Parametrised multiplexing controller for a common-anode FND (7-segment) display. It steps a digit position through `DIGITS` digits at a programmable dwell time. It inserts an anti-ghosting blank interval between digits and skips digits disabled by a run-time mask. It drives the digit-select lines and the position index consumed by the segment-data mux/decoder, and replaces the free-running 2-bit digit-position counter in the display path.

---
 rtl/fnd_scan_controller.sv | 152 +++++++++++++++
 tb/tb_fnd_scan_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Multiplexed scan controller for a common-anode 7-segment display; all outputs registered,
// first digit driven 1 cycle after enable. Free-running scan with no flow control.
module fnd_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    localparam int POS_W       = $clog2(DIGITS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [DIGITS-1:0] i_digitMask,
    output logic [POS_W-1:0]  o_digitPosition,
    output logic [DIGITS-1:0] o_digitSelect,
    output logic              o_blank,
    output logic              o_frameStart
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int GAP_W   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [DIGITS-1:0]  ALL_OFF    = '1;
    localparam logic [DIGITS-1:0]  ONE_HOT0   = DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [DIGITS-1:0]  sel_q, sel_d;
    logic               blank_q, blank_d;
    logic               frame_q, frame_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               advance;
    logic [POS_W-1:0]   next_pos;

    function automatic logic [POS_W-1:0] lowest_set(input logic [DIGITS-1:0] mask);
        lowest_set = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = POS_W'(i);
        end
    endfunction

    // Upward search with wrap: first candidate above cur, otherwise the lowest one below it.
    function automatic logic [POS_W-1:0] next_set(input logic [DIGITS-1:0] mask,
                                                  input logic [POS_W-1:0]  cur);
        logic found;
        next_set = cur;
        found    = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (!found && mask[j] && (j > int'(cur))) begin
                next_set = POS_W'(j);
                found    = 1'b1;
            end
        end
        for (int j = 0; j < DIGITS; j++) begin
            if (!found && mask[j] && (j < int'(cur))) begin
                next_set = POS_W'(j);
                found    = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            sel_q   <= ALL_OFF;
            blank_q <= 1'b1;
            frame_q <= 1'b0;
            dwell_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            frame_q <= frame_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        sel_d    = ALL_OFF;
        blank_d  = 1'b1;
        frame_d  = 1'b0;
        dwell_d  = '0;
        gap_d    = '0;
        advance  = 1'b0;
        next_pos = next_set(i_digitMask, pos_q);

        case (state_q)
            IDLE: begin
                if (i_enable && (i_digitMask != '0)) begin
                    state_d = SHOW;
                    pos_d   = lowest_set(i_digitMask);
                    frame_d = 1'b1;
                end
            end
            SHOW: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (dwell_q == DWELL_LAST) begin
                    if (BLANK_CYCLES > 0) state_d = BLANK;
                    else                  advance = 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            BLANK: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (gap_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The mask is only consulted here, so mid-dwell changes never alter timing.
        if (advance) begin
            if (i_digitMask == '0) begin
                state_d = IDLE;
            end else begin
                state_d = SHOW;
                pos_d   = next_pos;
                frame_d = (next_pos <= pos_q);
            end
        end

        if (state_d == SHOW) begin
            sel_d   = ~(ONE_HOT0 << pos_d);
            blank_d = 1'b0;
        end
    end

    assign o_digitPosition = pos_q;
    assign o_digitSelect   = sel_q;
    assign o_blank         = blank_q;
    assign o_frameStart    = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench: two controllers (blank interval 1 and 0) share stimulus; expected
// per-cycle outputs are generated from the scan timing formulas and queued per instance.
module tb_fnd_scan_controller;

    typedef struct {
        logic [1:0] pos;
        logic       chk_pos;
        logic [3:0] sel;
        logic       blank;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] mask;

    logic [1:0] pos1, pos0;
    logic [3:0] sel1, sel0;
    logic       blank1, blank0;
    logic       fs1, fs0;

    exp_t q1[$];
    exp_t q0[$];
    int   total = 0;
    int   bad   = 0;
    string phase = "reset";

    always #5 clk = ~clk;

    fnd_scan_controller #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1)) dut_b1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_digitMask(mask),
        .o_digitPosition(pos1), .o_digitSelect(sel1), .o_blank(blank1), .o_frameStart(fs1)
    );

    fnd_scan_controller #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0)) dut_b0 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_digitMask(mask),
        .o_digitPosition(pos0), .o_digitSelect(sel0), .o_blank(blank0), .o_frameStart(fs0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int which, input exp_t e);
        if (which == 1) q1.push_back(e);
        else            q0.push_back(e);
    endtask

    task automatic push_idle(input int which, input logic chk_pos, input logic [1:0] pos);
        exp_t e;
        e.pos = pos; e.chk_pos = chk_pos; e.sel = 4'b1111; e.blank = 1'b1; e.fs = 1'b0;
        push_exp(which, e);
    endtask

    // Expected trace from the first SHOW cycle: cycles [0,cut) scan, the rest idle.
    task automatic push_scan(input int which, input logic [3:0] m, input int blen,
                             input int cut, input int n);
        int   p[$];
        int   per, d, r, dig, last;
        exp_t e;
        logic [3:0] one;
        one  = 4'b0001;
        last = 0;
        for (int i = 0; i < 4; i++) if (m[i]) p.push_back(i);
        per = 4 + blen;
        for (int t = 0; t < n; t++) begin
            if (t < cut && p.size() > 0) begin
                d   = t / per;
                r   = t % per;
                dig = p[d % p.size()];
                last = dig;
                e.pos = 2'(dig);
                e.chk_pos = 1'b1;
                if (r < 4) begin
                    e.sel = ~(one << dig); e.blank = 1'b0;
                    e.fs  = (r == 0) && ((d % p.size()) == 0);
                end else begin
                    e.sel = 4'b1111; e.blank = 1'b1; e.fs = 1'b0;
                end
                push_exp(which, e);
            end else begin
                push_idle(which, 1'b1, 2'(last));
            end
        end
    endtask

    task automatic cmp_dut(input int which, input logic [1:0] pos, input logic [3:0] sel,
                           input logic bl, input logic fs);
        exp_t  e;
        string tg;
        tg = $sformatf("%s b%0d", phase, which);
        if (which == 1) begin
            check({tg, " q_depth"}, 32'(q1.size() > 0), 1);
            if (q1.size() == 0) return;
            e = q1.pop_front();
        end else begin
            check({tg, " q_depth"}, 32'(q0.size() > 0), 1);
            if (q0.size() == 0) return;
            e = q0.pop_front();
        end
        if (e.chk_pos) check({tg, " pos"}, 32'(pos), 32'(e.pos));
        check({tg, " sel"},   32'(sel), 32'(e.sel));
        check({tg, " blank"}, 32'(bl),  32'(e.blank));
        check({tg, " fs"},    32'(fs),  32'(e.fs));
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cmp_dut(1, pos1, sel1, blank1, fs1);
            cmp_dut(0, pos0, sel0, blank0, fs0);
        end
    endtask

    task automatic disable_one();
        phase = "disable";
        en = 1'b0;
        push_idle(1, 1'b0, 2'd0);
        push_idle(0, 1'b0, 2'd0);
        run(1);
    endtask

    task automatic start_scan(input string ph, input logic [3:0] m,
                              input int cut1, input int cut0, input int n);
        phase = ph;
        mask  = m;
        en    = 1'b1;
        push_scan(1, m, 1, cut1, n);
        push_scan(0, m, 0, cut0, n);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mask = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        push_idle(1, 1'b1, 2'd0);
        push_idle(0, 1'b1, 2'd0);
        cmp_dut(1, pos1, sel1, blank1, fs1);
        cmp_dut(0, pos0, sel0, blank0, fs0);

        rst = 1'b0;
        start_scan("mask1111", 4'b1111, 40, 40, 40);
        run(40);
        disable_one();

        start_scan("mask1010", 4'b1010, 30, 30, 30);
        run(30);
        disable_one();

        start_scan("mask0100", 4'b0100, 15, 15, 15);
        run(15);
        disable_one();

        start_scan("mask_to_0", 4'b1111, 5, 4, 8);
        run(2);
        mask = 4'b0000;
        run(6);
        disable_one();

        start_scan("pre_reset", 4'b1111, 12, 12, 12);
        run(12);
        phase = "drop_en";
        en = 1'b0;
        push_idle(1, 1'b1, 2'd2);
        push_idle(0, 1'b1, 2'd2);
        run(1);
        phase = "reset_pulse";
        rst = 1'b1;
        push_idle(1, 1'b1, 2'd0);
        push_idle(0, 1'b1, 2'd0);
        run(1);
        rst = 1'b0;
        start_scan("reenable", 4'b1100, 10, 10, 10);
        run(10);

        phase = "end";
        check("q1 leftover", 32'(q1.size()), 0);
        check("q0 leftover", 32'(q0.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
